// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding, error codes and instruction field positions
// for the ALU issue controller and its register file.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_MUL  = 4'd2;
   localparam logic [3:0] ALU_DIV  = 4'd3;
   localparam logic [3:0] ALU_MOD  = 4'd4;
   localparam logic [3:0] ALU_SHL  = 4'd5;
   localparam logic [3:0] ALU_SHR  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_ZERO = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_OR   = 4'd10;
   localparam logic [3:0] ALU_NOT  = 4'd11;
   localparam logic [3:0] OP_LDI   = 4'd12;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_DIV0    = 2'd2;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 8;
   localparam int RS2_MSB = 7;
   localparam int RS2_LSB = 6;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_ERR
   } state_t;

   function automatic logic is_illegal(input logic [3:0] opc);
      return opc > OP_LDI;
   endfunction

   function automatic logic needs_nonzero_rs2(input logic [3:0] opc);
      return (opc == ALU_DIV) || (opc == ALU_MOD);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x16 register file: two operand read ports, one debug read port, one write port.
// Reads are combinational; the write lands on the rising edge.
module alu_regfile
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_vld,
   input  logic [1:0]  wr_addr,
   input  logic [15:0] wr_dat,
   input  logic [1:0]  rd1_addr,
   input  logic [1:0]  rd2_addr,
   input  logic [1:0]  dbg_addr,
   output logic [15:0] rd1_dat,
   output logic [15:0] rd2_dat,
   output logic [15:0] dbg_dat
);

   logic [15:0] rf_q [4];
   logic [15:0] rf_d [4];

   always_comb begin
      rf_d = rf_q;
      if (wr_vld) begin
         rf_d[wr_addr] = wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_q <= '{default: '0};
      end else begin
         rf_q <= rf_d;
      end
   end

   assign rd1_dat = rf_q[rd1_addr];
   assign rd2_dat = rf_q[rd2_addr];
   assign dbg_dat = rf_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding a combinational ALU: accept, decode/fault-check, execute, write back.
// Success takes 4 cycles from acceptance to next acceptance, errors take 3; instr_ready is high only in IDLE.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_z,
   output logic        done,
   output logic [15:0] result,
   output logic        err,
   output logic [1:0]  err_code,
   input  logic [1:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   state_t      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] alu_in1_q, alu_in1_d;
   logic [15:0] alu_in2_q, alu_in2_d;
   logic [3:0]  alu_op_q, alu_op_d;
   logic [15:0] result_q, result_d;
   logic [1:0]  err_code_q, err_code_d;

   logic [3:0]  opc;
   logic [1:0]  rd, rs1, rs2;
   logic [7:0]  imm8;
   logic [15:0] rs1_dat, rs2_dat;

   assign opc  = instr_q[OPC_MSB:OPC_LSB];
   assign rd   = instr_q[RD_MSB:RD_LSB];
   assign rs1  = instr_q[RS1_MSB:RS1_LSB];
   assign rs2  = instr_q[RS2_MSB:RS2_LSB];
   assign imm8 = instr_q[IMM_MSB:IMM_LSB];

   // Write-back is tied to the WB state, so a reset there cancels the write.
   alu_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_vld   (state_q == ST_WB),
      .wr_addr  (rd),
      .wr_dat   (result_q),
      .rd1_addr (rs1),
      .rd2_addr (rs2),
      .dbg_addr (dbg_addr),
      .rd1_dat  (rs1_dat),
      .rd2_dat  (rs2_dat),
      .dbg_dat  (dbg_data)
   );

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      alu_in1_d  = alu_in1_q;
      alu_in2_d  = alu_in2_q;
      alu_op_d   = alu_op_q;
      result_d   = result_q;
      err_code_d = err_code_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_illegal(opc)) begin
               err_code_d = ERR_ILLEGAL;
               state_d    = ST_ERR;
            end else if (needs_nonzero_rs2(opc) && (rs2_dat == 16'h0000)) begin
               err_code_d = ERR_DIV0;
               state_d    = ST_ERR;
            end else begin
               state_d = ST_EXEC;
               // LDI reuses the ALU adder: imm8 + 0 gives the zero-extended immediate.
               if (opc == OP_LDI) begin
                  alu_op_d  = ALU_ADD;
                  alu_in1_d = {8'h00, imm8};
                  alu_in2_d = 16'h0000;
               end else begin
                  alu_op_d  = opc;
                  alu_in1_d = rs1_dat;
                  alu_in2_d = ((opc == ALU_NOT) || (opc == ALU_ZERO)) ? 16'h0000 : rs2_dat;
               end
            end
         end
         ST_EXEC: begin
            result_d = alu_z;
            state_d  = ST_WB;
         end
         ST_WB:   state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         instr_q    <= '0;
         alu_in1_q  <= '0;
         alu_in2_q  <= '0;
         alu_op_q   <= '0;
         result_q   <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         alu_in1_q  <= alu_in1_d;
         alu_in2_q  <= alu_in2_d;
         alu_op_q   <= alu_op_d;
         result_q   <= result_d;
         err_code_q <= err_code_d;
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign done        = (state_q == ST_WB);
   assign err         = (state_q == ST_ERR);
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_op      = alu_op_q;
   assign result      = result_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, hand-written handshake/reset
// sequences, and random instructions checked against a per-instruction reference model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = 16'h0000;
   logic [15:0] alu_in1, alu_in2;
   logic [3:0]  alu_op;
   logic [15:0] alu_z;
   logic        done;
   logic [15:0] result;
   logic        err;
   logic [1:0]  err_code;
   logic [1:0]  dbg_addr = 2'd0;
   logic [15:0] dbg_data;

   int checks = 0;
   int failures = 0;

   alu_issue_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_op      (alu_op),
      .alu_z       (alu_z),
      .done        (done),
      .result      (result),
      .err         (err),
      .err_code    (err_code),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural 16-bit ALU standing in for the CPU-level ALU.
   function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a * b;
         4'd3:    return (b == 16'h0) ? 16'hFFFF : a / b;
         4'd4:    return (b == 16'h0) ? 16'hFFFF : a % b;
         4'd5:    return a << b;
         4'd6:    return a >> b;
         4'd7:    return $signed(a) >>> b;
         4'd8:    return 16'h0000;
         4'd9:    return a & b;
         4'd10:   return a | b;
         4'd11:   return ~a;
         default: return 16'h0000;
      endcase
   endfunction

   always_comb alu_z = alu_ref(alu_op, alu_in1, alu_in2);

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Entered just after a falling edge; leaves just after the falling edge of cycle 4 after acceptance.
   task automatic run_instr(input logic [15:0] ins, input logic exp_err, input logic [1:0] exp_code,
                            input logic [15:0] exp_val, input logic [15:0] exp_dbg, input logic chk_ops,
                            input logic [15:0] e_in1, input logic [15:0] e_in2, input logic [3:0] e_op);
      int n;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("accept_ready", instr_ready, 1'b1);
      instr       = ins;
      instr_valid = 1'b1;
      dbg_addr    = ins[11:10];
      @(negedge clk);
      instr_valid = 1'b0;
      chk1("decode_busy", instr_ready, 1'b0);
      chk1("decode_done", done, 1'b0);
      chk1("decode_err", err, 1'b0);
      @(negedge clk);
      chk1("cyc2_err", err, exp_err);
      chk1("cyc2_done", done, 1'b0);
      if (exp_err) begin
         chk("cyc2_err_code", {14'h0, err_code}, {14'h0, exp_code});
      end else if (chk_ops) begin
         chk("exec_in1", alu_in1, e_in1);
         chk("exec_in2", alu_in2, e_in2);
         chk("exec_op", {12'h0, alu_op}, {12'h0, e_op});
      end
      @(negedge clk);
      chk1("cyc3_done", done, ~exp_err);
      chk1("cyc3_err", err, 1'b0);
      chk1("cyc3_ready", instr_ready, exp_err);
      if (exp_err) begin
         chk("err_code_held", {14'h0, err_code}, {14'h0, exp_code});
      end else begin
         chk("wb_result", result, exp_val);
      end
      @(negedge clk);
      chk1("cyc4_done", done, 1'b0);
      chk1("cyc4_ready", instr_ready, 1'b1);
      chk("dbg_rd", dbg_data, exp_dbg);
   endtask

   typedef struct {
      logic [15:0] ins;
      logic        is_err;
      logic [1:0]  code;
      logic [15:0] val;
      logic [15:0] dbg;
   } vec_t;

   vec_t        tbl [17];
   logic [15:0] seq [3];
   logic [15:0] mrf [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  rdy_pat;
      logic [6:0]  err_pat;
      int          k;
      int          n;
      logic [15:0] ins;
      logic [3:0]  op;
      logic        e_err;
      logic [1:0]  e_code;
      logic [15:0] e_in1, e_in2, e_val;
      logic [3:0]  e_op;

      tbl[0]  = '{16'hC405, 1'b0, 2'd0, 16'h0005, 16'h0005}; // LDI r1,5
      tbl[1]  = '{16'hC803, 1'b0, 2'd0, 16'h0003, 16'h0003}; // LDI r2,3
      tbl[2]  = '{16'h1180, 1'b0, 2'd0, 16'h0002, 16'h0002}; // SUB r0,r1,r2
      tbl[3]  = '{16'hC480, 1'b0, 2'd0, 16'h0080, 16'h0080}; // LDI r1,0x80
      tbl[4]  = '{16'h2D40, 1'b0, 2'd0, 16'h4000, 16'h4000}; // MUL r3,r1,r1
      tbl[5]  = '{16'hC410, 1'b0, 2'd0, 16'h0010, 16'h0010}; // LDI r1,0x10
      tbl[6]  = '{16'h2540, 1'b0, 2'd0, 16'h0100, 16'h0100}; // MUL r1,r1,r1
      tbl[7]  = '{16'h2D40, 1'b0, 2'd0, 16'h0000, 16'h0000}; // MUL r3,r1,r1 truncates
      tbl[8]  = '{16'hC800, 1'b0, 2'd0, 16'h0000, 16'h0000}; // LDI r2,0
      tbl[9]  = '{16'h3180, 1'b1, 2'd2, 16'h0000, 16'h0002}; // DIV r0,r1,r2 by zero
      tbl[10] = '{16'hE000, 1'b1, 2'd1, 16'h0000, 16'h0002}; // illegal
      tbl[11] = '{16'h4180, 1'b1, 2'd2, 16'h0000, 16'h0002}; // modulo by zero
      tbl[12] = '{16'hC814, 1'b0, 2'd0, 16'h0014, 16'h0014}; // LDI r2,20
      tbl[13] = '{16'hB580, 1'b0, 2'd0, 16'hFEFF, 16'hFEFF}; // NOT r1,r1
      tbl[14] = '{16'h5180, 1'b0, 2'd0, 16'h0000, 16'h0000}; // SHL by 20
      tbl[15] = '{16'h7180, 1'b0, 2'd0, 16'hFFFF, 16'hFFFF}; // SRA by 20
      tbl[16] = '{16'h6180, 1'b0, 2'd0, 16'h0000, 16'h0000}; // SHR by 20

      // Reset values
      @(negedge clk);
      chk1("rst_ready", instr_ready, 1'b1);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk("rst_in1", alu_in1, 16'h0);
      chk("rst_in2", alu_in2, 16'h0);
      chk("rst_op", {12'h0, alu_op}, 16'h0);
      chk("rst_result", result, 16'h0);
      chk("rst_err_code", {14'h0, err_code}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         run_instr(tbl[i].ins, tbl[i].is_err, tbl[i].code, tbl[i].val, tbl[i].dbg,
                   1'b0, 16'h0, 16'h0, 4'h0);
      end

      // Back-to-back LDIs with valid held; instr carries junk while busy.
      seq[0] = 16'hC011;
      seq[1] = 16'hC422;
      seq[2] = 16'hC833;
      k = 0;
      instr_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk1("b2b_ready", instr_ready, (c % 4) == 0);
         if (instr_ready && k < 3) begin
            instr = seq[k];
            k++;
         end
         @(posedge clk);
         #1;
         instr = 16'hE3FF;
         if (k == 3 && !instr_ready) instr_valid = 1'b0;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      dbg_addr = 2'd0; #1 chk("b2b_r0", dbg_data, 16'h0011);
      dbg_addr = 2'd1; #1 chk("b2b_r1", dbg_data, 16'h0022);
      dbg_addr = 2'd2; #1 chk("b2b_r2", dbg_data, 16'h0033);
      @(negedge clk);

      // Held illegal instruction is re-accepted only after returning to IDLE.
      rdy_pat = 7'b1001001;
      err_pat = 7'b0100100;
      instr = 16'hE000;
      instr_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         chk1("ill_ready", instr_ready, rdy_pat[c]);
         chk1("ill_err", err, err_pat[c]);
         chk1("ill_done", done, 1'b0);
         if (err_pat[c]) chk("ill_code", {14'h0, err_code}, 16'h0001);
         if (c == 5) instr_valid = 1'b0;
         @(negedge clk);
      end

      // Reset during EXEC of ADD r0,r1,r2
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      instr = 16'h0180;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_ready", instr_ready, 1'b1);
      chk1("mid_rst_done", done, 1'b0);
      chk1("mid_rst_err", err, 1'b0);
      chk("mid_rst_in1", alu_in1, 16'h0);
      chk("mid_rst_in2", alu_in2, 16'h0);
      chk("mid_rst_op", {12'h0, alu_op}, 16'h0);
      chk("mid_rst_result", result, 16'h0);
      chk("mid_rst_err_code", {14'h0, err_code}, 16'h0);
      for (int a = 0; a < 4; a++) begin
         dbg_addr = a[1:0];
         #1 chk("mid_rst_rf", dbg_data, 16'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk1("post_rst_done", done, 1'b0);
         chk1("post_rst_ready", instr_ready, 1'b1);
      end

      // Random instructions against the reference model.
      foreach (mrf[i]) mrf[i] = 16'h0;
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 9) < 3) begin
            ins = {4'hC, 4'($urandom_range(0, 3) << 2), 8'($urandom_range(0, 255))};
         end else begin
            ins = 16'($urandom);
         end
         op    = ins[15:12];
         e_err = 1'b0;
         e_code = 2'd0;
         e_in1 = 16'h0;
         e_in2 = 16'h0;
         e_op  = 4'h0;
         e_val = 16'h0;
         if (op >= 4'd13) begin
            e_err  = 1'b1;
            e_code = 2'd1;
         end else if ((op == 4'd3 || op == 4'd4) && mrf[ins[7:6]] == 16'h0) begin
            e_err  = 1'b1;
            e_code = 2'd2;
         end else begin
            e_op  = (op == 4'd12) ? 4'd0 : op;
            e_in1 = (op == 4'd12) ? {8'h00, ins[7:0]} : mrf[ins[9:8]];
            e_in2 = (op == 4'd12 || op == 4'd8 || op == 4'd11) ? 16'h0 : mrf[ins[7:6]];
            e_val = alu_ref(e_op, e_in1, e_in2);
            mrf[ins[11:10]] = e_val;
         end
         run_instr(ins, e_err, e_code, e_val, mrf[ins[11:10]], 1'b1, e_in1, e_in2, e_op);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing controller that drives the 16-bit combinational ALU from the producer side: it accepts 16-bit instructions over a valid/ready handshake, reads operands from a 4-entry register file, presents `in1`/`in2`/`alu_op` to the ALU and captures `Z`. It then writes the result back and reports completion or error. It sits between the instruction source (test sequencer or fetch unit) and the ALU in the single-instruction CPU.

## Interface
- Parameters: none. Widths are fixed: 16-bit data, 4-bit op, 4 registers.
- `clk`  in  1  — sole clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `instr_valid`  in  1  — instruction present.
- `instr_ready`  out  1  — controller can accept; high only in IDLE.
- `instr`  in  16  — `[15:12]` opcode, `[11:10]` rd, `[9:8]` rs1, `[7:6]` rs2, `[7:0]` imm8 (LDI only).
- `alu_in1`, `alu_in2`  out  16  — ALU operands (registered).
- `alu_op`  out  4  — ALU operation select (registered).
- `alu_z`  in  16  — ALU result (combinational return).
- `done`  out  1  — one-cycle pulse; write-back in progress.
- `result`  out  16  — value being written; valid while `done`=1, held afterwards.
- `err`  out  1  — one-cycle pulse; instruction aborted.
- `err_code`  out  2  — `1` illegal opcode, `2` divide/modulo by zero; valid while `err`=1, held afterwards.
- `dbg_addr`  in  2  — debug register select.
- `dbg_data`  out  16  — combinational read of `rf[dbg_addr]`.

## Operation
- **Opcodes 0–11** pass straight through as `alu_op`:
  - 0 ADD, 1 SUB, 2 MUL (low 16 bits), 3 DIV, 4 MOD
  - 5 SHL, 6 SHR, 7 SRA (`in1` arithmetically shifted by `in2`), 8 ZERO
  - 9 AND, 10 OR, 11 NOT
- **Opcode 12 LDI**: `alu_op`=0, `alu_in1`={8'h00, imm8}, `alu_in2`=0. The ALU add yields the zero-extended immediate.
- **Opcodes 13–15**: illegal.
- **Operand routing**: `alu_in1`=`rf[rs1]` and `alu_in2`=`rf[rs2]`. For NOT (11) and ZERO (8), `alu_in2` is forced to 0.
- **FSM states**: IDLE, DECODE, EXEC, WB, ERR.
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to DECODE.
  - DECODE: read operands and check faults.
    - Illegal opcode → ERR with code 1.
    - Op 3 or 4 with `rf[rs2]`==0 → ERR with code 2.
    - Otherwise load `alu_in1`/`alu_in2`/`alu_op` and go to EXEC.
  - EXEC: ALU outputs are stable; sample `alu_z` into `result` at the end of the cycle; go to WB.
  - WB: `done`=1; `rf[rd]` <= `result` at the end of the cycle; go to IDLE.
  - ERR: `err`=1 for one cycle; no register write; go to IDLE.
- **Register file**:
  - 4×16, all entries reset to 0.
  - rd may equal rs1/rs2: operands are read in DECODE, before the write.
  - `dbg_data` shows the new value from the cycle after the WB edge.
- **ALU outputs**: `alu_in1`/`alu_in2`/`alu_op` hold their last value outside DECODE→EXEC.

## Timing
- **Reset values**: state IDLE; `instr_ready`=1 (combinational from IDLE state); `alu_in1`/`alu_in2`/`result` = 0; `alu_op`=0; `done`=0; `err`=0; `err_code`=0; all registers 0.
- **Acceptance**: an instruction is accepted at the edge where `instr_valid` and `instr_ready` are both high (edge A).
- **Success path**:
  - DECODE in the cycle after A, EXEC in the next, WB in the next.
  - `done` is high in the 3rd cycle after A.
  - Next acceptance is possible at the 4th edge after A.
- **Error path**: `err` is high in the 2nd cycle after A; next acceptance is possible at the 3rd edge after A.
- **Busy**: `instr_ready`=0 in DECODE/EXEC/WB/ERR. `instr` is ignored there; the source must hold `instr_valid`.
- **Shift amounts ≥ 16**: passed through unchanged; the result is whatever the ALU produces.
- **Reset asserted in any state**: immediate return to IDLE with all reset values. A pending `done`/`err` is lost and any pending write is cancelled.
- **`done` and `err`** are never high in the same cycle.

## Structure
- **Package `alu_pkg`**:
  - opcode constants `ALU_ADD`…`ALU_NOT`, `OP_LDI`
  - FSM state encoding
  - `ERR_ILLEGAL`=1, `ERR_DIV0`=2
  - field-slice constants for `instr`
- **Sub-module `alu_regfile`**: 4×16 registers; two read ports for operands, one debug read port, one write port; asynchronous active-low clear.
- The ALU itself is instantiated outside this block, in the CPU top level.

## Test plan
- LDI r1,5; LDI r2,3; SUB r0,r1,r2 → `result`=0x0002 with `done` 3 cycles after acceptance; `dbg_data`(r0)=0x0002.
- LDI r1,0x80 then MUL r3,r1,r1 → `result`=0x4000; with r1 loaded with 0x0100 (r1 ← r1×r1), MUL r3,r1,r1 → `result`=0x0000 (truncation).
- DIV r0,r1,r2 with r2=0 → `err`=1 and `err_code`=2 in the 2nd cycle after A; `done` never asserts; r0 unchanged.
- `instr`=0xE000 → `err_code`=1; held `instr_valid` is re-accepted only after return to IDLE.
- Back-to-back: `instr_valid` held for 3 LDIs → `instr_ready` pulses exactly every 4 cycles; all three writes land.
- `rst_n` low during EXEC of ADD → no `done`; all outputs at reset values; registers read 0.
